// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//
// Sequences the shared iterative multiplier/divider for the 5-stage pipeline.
// When a mul/div instruction sits in DX, the block latches its operands and
// destination register and launches the unit. It holds PC/FD/DX frozen until
// the result is back, then injects the result into the DX->XM transfer. If
// the unit reports an exception, it injects an rstatus (r30) write instead.
//
// Optional feature (compile-time macro MULTDIV_TIMEOUT_EN):
//   A BUSY-state watchdog. After MAX_WAIT BUSY cycles with no resultRDY, the
//   sequencer completes with an EXC_TMO exception. Without the macro, BUSY
//   waits indefinitely.
//
// Ports:
//   clock           in   pipeline clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   DX_instruction  in   instruction currently in DX
//   DX_A, DX_B      in   bypassed operands of the DX instruction
//   flush_DX        in   kills the DX instruction
//   data_resultRDY  in   unit result valid (1-cycle pulse)
//   data_exception  in   unit overflow / divide-by-zero, valid with resultRDY
//   data_result     in   unit result
//   ctrl_MULT       out  1-cycle start-multiply pulse
//   ctrl_DIV        out  1-cycle start-divide pulse
//   md_A, md_B      out  latched operands, stable from START until RDY
//   stall           out  freeze PC/FD/DX and bubble XM
//   md_valid        out  override XM_O / write reg for the DX->XM transfer
//   md_write_reg    out  rd, or 5'd30 on exception
//   md_write_data   out  result, or the exception code
// -----------------------------------------------------------------------------
module multdiv_sequencer #(
    parameter int          MAX_WAIT = 64,
    parameter logic [31:0] EXC_MUL  = 32'd4,
    parameter logic [31:0] EXC_DIV  = 32'd5,
    parameter logic [31:0] EXC_TMO  = 32'd6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] DX_instruction,
    input  logic [31:0] DX_A,
    input  logic [31:0] DX_B,
    input  logic        flush_DX,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    input  logic [31:0] data_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_A,
    output logic [31:0] md_B,
    output logic        stall,
    output logic        md_valid,
    output logic [4:0]  md_write_reg,
    output logic [31:0] md_write_data
);

    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;
    localparam logic [4:0] REG_RSTAT = 5'd30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e      state_q;
    logic        op_div_q;
    logic [4:0]  rd_q;
    logic [31:0] md_a_q;
    logic [31:0] md_b_q;
    logic        ctrl_mult_q;
    logic        ctrl_div_q;
    logic        md_valid_q;
    logic [4:0]  wreg_q;
    logic [31:0] wdata_q;

    logic        is_md_s;
    logic        is_div_s;
    logic        detect_s;

`ifdef MULTDIV_TIMEOUT_EN
    logic [6:0]  wait_cnt_q;
`else
    // Watchdog configuration is not needed when the timeout is compiled out.
    logic        unused_cfg_s;
    assign unused_cfg_s = ^{EXC_TMO, 32'(MAX_WAIT)};
`endif

    // Register/shamt fields and the low aluop padding are not needed for md decode.
    logic        unused_instr_s;
    assign unused_instr_s = ^{DX_instruction[21:7], DX_instruction[1:0]};

    // Decode mul/div in DX; a flushed instruction is never launched.
    always_comb begin
        is_md_s  = 1'b0;
        is_div_s = 1'b0;
        if (DX_instruction[31:27] == 5'b00000) begin
            case (DX_instruction[6:2])
                ALUOP_MUL: begin
                    is_md_s  = 1'b1;
                    is_div_s = 1'b0;
                end
                ALUOP_DIV: begin
                    is_md_s  = 1'b1;
                    is_div_s = 1'b1;
                end
                default: begin
                    is_md_s  = 1'b0;
                    is_div_s = 1'b0;
                end
            endcase
        end else begin
            is_md_s  = 1'b0;
            is_div_s = 1'b0;
        end
        detect_s = is_md_s && !flush_DX;
    end

    // The detect cycle must stall combinationally so DX holds the instruction;
    // reset_n gating keeps stall at 0 while reset is asserted.
    assign stall = reset_n &&
                   (((state_q == S_IDLE) && detect_s) ||
                    (state_q == S_START) || (state_q == S_BUSY));

    // Sequencer FSM with registered launch and write-back outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_div_q    <= 1'b0;
            rd_q        <= 5'd0;
            md_a_q      <= 32'd0;
            md_b_q      <= 32'd0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            md_valid_q  <= 1'b0;
            wreg_q      <= 5'd0;
            wdata_q     <= 32'd0;
`ifdef MULTDIV_TIMEOUT_EN
            wait_cnt_q  <= 7'd0;
`endif
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            md_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (detect_s) begin
                        op_div_q    <= is_div_s;
                        rd_q        <= DX_instruction[26:22];
                        md_a_q      <= DX_A;
                        md_b_q      <= DX_B;
                        ctrl_mult_q <= !is_div_s;
                        ctrl_div_q  <= is_div_s;
                        state_q     <= S_START;
                    end else begin
                        state_q     <= S_IDLE;
                    end
                end
                S_START: begin
`ifdef MULTDIV_TIMEOUT_EN
                    wait_cnt_q <= 7'd0;
`endif
                    // An abort after launch is safe: the next launch restarts the unit.
                    if (flush_DX) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Flush wins over a coincident result.
                    if (flush_DX) begin
                        state_q <= S_IDLE;
                    end else if (data_resultRDY) begin
                        md_valid_q <= 1'b1;
                        state_q    <= S_DONE;
                        if (data_exception) begin
                            wreg_q  <= REG_RSTAT;
                            wdata_q <= op_div_q ? EXC_DIV : EXC_MUL;
                        end else begin
                            wreg_q  <= rd_q;
                            wdata_q <= data_result;
                        end
`ifdef MULTDIV_TIMEOUT_EN
                    end else if (wait_cnt_q == 7'(MAX_WAIT - 1)) begin
                        md_valid_q <= 1'b1;
                        wreg_q     <= REG_RSTAT;
                        wdata_q    <= EXC_TMO;
                        state_q    <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 7'd1;
                        state_q    <= S_BUSY;
                    end
`else
                    end else begin
                        state_q <= S_BUSY;
                    end
`endif
                end
                S_DONE: begin
                    // The same instruction is still in DX; never re-detect here.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_MULT     = ctrl_mult_q;
    assign ctrl_DIV      = ctrl_div_q;
    assign md_A          = md_a_q;
    assign md_B          = md_b_q;
    assign md_valid      = md_valid_q;
    assign md_write_reg  = wreg_q;
    assign md_write_data = wdata_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int MW  = 8;
    localparam bit TMO = 1'b1;
`else
    localparam int MW  = 64;
    localparam bit TMO = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] DX_instruction, DX_A, DX_B, data_result;
    logic        flush_DX, data_resultRDY, data_exception;
    logic        ctrl_MULT, ctrl_DIV, stall, md_valid;
    logic [31:0] md_A, md_B, md_write_data;
    logic [4:0]  md_write_reg;

    always #5 clock = ~clock;

    multdiv_sequencer #(.MAX_WAIT(MW)) dut (
        .clock(clock), .reset_n(reset_n), .DX_instruction(DX_instruction),
        .DX_A(DX_A), .DX_B(DX_B), .flush_DX(flush_DX),
        .data_resultRDY(data_resultRDY), .data_exception(data_exception),
        .data_result(data_result), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .md_A(md_A), .md_B(md_B), .stall(stall), .md_valid(md_valid),
        .md_write_reg(md_write_reg), .md_write_data(md_write_data)
    );

    typedef struct {
        logic        is_div;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        string       name;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[6];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          stall_cnt, mul_cnt, div_cnt, valid_cnt;
    int          cd = 0;
    int          cur_lat = 0;
    logic [31:0] m_res = 32'd0;
    logic        m_exc = 1'b0;
    logic [31:0] exp_a, exp_b;
    logic [31:0] nxt_instr, nxt_a, nxt_b;
    logic        nxt_flush;

    function automatic logic [31:0] enc(input logic is_div, input logic [4:0] rd);
        return {5'd0, rd, 5'd1, 5'd2, 5'd0, (is_div ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural unit: computes result/exception from the operands it was launched with.
    task automatic unit_launch(input logic is_div);
        longint p;
        int ai, bi;
        ai = md_A;
        bi = md_B;
        m_exc = 1'b0;
        m_res = 32'd0;
        if (is_div) begin
            if (bi == 0 || (md_A == 32'h8000_0000 && md_B == 32'hFFFF_FFFF)) m_exc = 1'b1;
            else m_res = ai / bi;
        end else begin
            p = longint'(ai) * longint'(bi);
            m_res = p[31:0];
            m_exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end
        if (cur_lat > 0) cd = cur_lat;
        chk("md_A at launch", {32'd0, md_A}, {32'd0, exp_a});
        chk("md_B at launch", {32'd0, md_B}, {32'd0, exp_b});
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clock);
        DX_instruction = nxt_instr;
        DX_A = nxt_a;
        DX_B = nxt_b;
        flush_DX = nxt_flush;
        if (cd > 0) begin
            cd--;
            data_resultRDY = (cd == 0);
        end else begin
            data_resultRDY = 1'b0;
        end
        data_result = m_res;
        data_exception = m_exc;
        #1;
        if (stall) stall_cnt++;
        if (ctrl_MULT) begin mul_cnt++; unit_launch(1'b0); end
        if (ctrl_DIV)  begin div_cnt++; unit_launch(1'b1); end
        if (md_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected md_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, " reg"}, {59'd0, md_write_reg}, {59'd0, e.r});
                chk({e.name, " data"}, {32'd0, md_write_data}, {32'd0, e.d});
            end
        end
    endtask

    task automatic clr_counts();
        stall_cnt = 0; mul_cnt = 0; div_cnt = 0; valid_cnt = 0;
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   exp_stall;
        e.r = v.exp_reg; e.d = v.exp_data; e.name = v.name;
        exp_stall = v.lat + 2;
        if (TMO && (v.lat == 0 || v.lat > MW)) begin
            e.r = 5'd30; e.d = 32'd6; exp_stall = MW + 2;
        end
        sb.push_back(e);
        clr_counts();
        cur_lat = v.lat; exp_a = v.a; exp_b = v.b;
        nxt_instr = enc(v.is_div, v.rd); nxt_a = v.a; nxt_b = v.b; nxt_flush = 1'b0;
        for (int i = 0; i < 300 && valid_cnt == 0; i++) cycle();
        chk({v.name, " md_valid count"}, 64'(valid_cnt), 64'd1);
        chk({v.name, " stall cycles"}, 64'(stall_cnt), 64'(exp_stall));
        chk({v.name, " mult pulses"}, 64'(mul_cnt), v.is_div ? 64'd0 : 64'd1);
        chk({v.name, " div pulses"}, 64'(div_cnt), v.is_div ? 64'd1 : 64'd0);
        nxt_instr = NOP; nxt_a = 32'd0; nxt_b = 32'd0;
    endtask

    task automatic idle(input int n, input string nm);
        clr_counts();
        for (int i = 0; i < n; i++) cycle();
        chk({nm, " idle pulses"}, 64'(mul_cnt + div_cnt), 64'd0);
        chk({nm, " idle md_valid"}, 64'(valid_cnt), 64'd0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " stall"}, {63'd0, stall}, 64'd0);
        chk({nm, " ctrl_MULT"}, {63'd0, ctrl_MULT}, 64'd0);
        chk({nm, " ctrl_DIV"}, {63'd0, ctrl_DIV}, 64'd0);
        chk({nm, " md_valid"}, {63'd0, md_valid}, 64'd0);
        chk({nm, " md_write_reg"}, {59'd0, md_write_reg}, 64'd0);
        chk({nm, " md_write_data"}, {32'd0, md_write_data}, 64'd0);
        chk({nm, " md_A"}, {32'd0, md_A}, 64'd0);
        chk({nm, " md_B"}, {32'd0, md_B}, 64'd0);
    endtask

    task automatic launch_and_wait(input logic is_div, input int lat, input logic [31:0] a,
                                   input logic [31:0] b, input string nm);
        clr_counts();
        cur_lat = lat; exp_a = a; exp_b = b;
        nxt_instr = enc(is_div, 5'd9); nxt_a = a; nxt_b = b; nxt_flush = 1'b0;
        for (int i = 0; i < 20 && (mul_cnt + div_cnt) == 0; i++) cycle();
        chk({nm, " launch"}, 64'(mul_cnt + div_cnt), 64'd1);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{1'b0, 5'd3,  32'd7,          32'd6,          32, 5'd3,  32'd42,         "mul 7x6"};
        tbl[1] = '{1'b1, 5'd4,  32'd100,        32'd0,          8,  5'd30, 32'd5,          "div by zero"};
        tbl[2] = '{1'b0, 5'd5,  32'h4000_0000,  32'd4,          4,  5'd30, 32'd4,          "mul overflow"};
        tbl[3] = '{1'b1, 5'd6,  32'hFFFF_FF9C,  32'd7,          5,  5'd6,  32'hFFFF_FFF2,  "div -100/7"};
        tbl[4] = '{1'b0, 5'd31, 32'hFFFF_FFFD,  32'd5,          1,  5'd31, 32'hFFFF_FFF1,  "mul -3x5 L1"};
        tbl[5] = '{1'b1, 5'd1,  32'h8000_0000,  32'hFFFF_FFFF,  2,  5'd30, 32'd5,          "div min/-1"};

        // Reset with a mul in DX: outputs must still read 0.
        reset_n = 1'b0;
        DX_instruction = enc(1'b0, 5'd3); DX_A = 32'd7; DX_B = 32'd6;
        flush_DX = 1'b0; data_resultRDY = 1'b0; data_exception = 1'b0; data_result = 32'd0;
        nxt_instr = NOP; nxt_a = 32'd0; nxt_b = 32'd0; nxt_flush = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        DX_instruction = NOP;
        idle(2, "post reset");

        foreach (tbl[i]) begin
            run_op(tbl[i]);
            idle(3, tbl[i].name);
        end

        // Right aluop but non-zero opcode is not a mul.
        nxt_instr = {5'b00101, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
        clr_counts();
        cycle();
        chk("non-md opcode stall", {63'd0, stall}, 64'd0);
        nxt_instr = NOP;
        idle(3, "non-md opcode");

        // Flushed mul in IDLE neither stalls nor launches.
        nxt_instr = enc(1'b0, 5'd3); nxt_a = 32'd7; nxt_b = 32'd6; nxt_flush = 1'b1;
        cycle();
        chk("flush on detect stall", {63'd0, stall}, 64'd0);
        nxt_flush = 1'b0; nxt_instr = NOP;
        idle(3, "flush on detect");

        // Back-to-back mul then div.
        v = '{1'b0, 5'd7, 32'd9, 32'd9, 3, 5'd7, 32'd81, "b2b mul"};
        run_op(v);
        v = '{1'b1, 5'd8, 32'd81, 32'd9, 4, 5'd8, 32'd9, "b2b div"};
        run_op(v);
        idle(4, "b2b");

        // Flush in BUSY cycle 5 with L=32; the later stale RDY must be ignored.
        launch_and_wait(1'b0, 32, 32'd11, 32'd13, "busy flush");
        repeat (4) cycle();
        nxt_flush = 1'b1;
        cycle();
        chk("busy flush stall count", 64'(stall_cnt), 64'd7);
        nxt_flush = 1'b0; nxt_instr = NOP;
        cycle();
        chk("busy flush stall drops", {63'd0, stall}, 64'd0);
        idle(32, "busy flush stale RDY");

        // RDY coincident with flush in BUSY: result dropped.
        launch_and_wait(1'b1, 3, 32'd50, 32'd5, "rdy+flush");
        repeat (2) cycle();
        nxt_flush = 1'b1;
        cycle();
        chk("rdy+flush stall count", 64'(stall_cnt), 64'd5);
        nxt_flush = 1'b0; nxt_instr = NOP;
        idle(4, "rdy+flush");

        // Async reset during BUSY with the mul still in DX.
        launch_and_wait(1'b0, 32, 32'd3, 32'd5, "reset busy");
        repeat (3) cycle();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset in busy");
        cd = 0;
        nxt_instr = NOP; nxt_a = 32'd0; nxt_b = 32'd0;
        cycle();
        reset_n = 1'b1;
        idle(3, "after busy reset");

`ifdef MULTDIV_TIMEOUT_EN
        v = '{1'b0, 5'd12, 32'd2, 32'd3, 0, 5'd30, 32'd6, "watchdog"};
        run_op(v);
        idle(3, "watchdog");
`endif

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
